// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: WB stage vs. multi-cycle unit with a 1-entry skid buffer.
// Optional ID-stage bypass outputs when RFW_BYPASS_EN is defined.
module rf_write_scheduler #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        id_stall,
`ifdef RFW_BYPASS_EN
  output logic        byp1_hit,
  output logic [31:0] byp1_data,
  output logic        byp2_hit,
  output logic [31:0] byp2_data,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUT);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_LIM);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;

  buf_state_t     buf_state_r;
  logic [4:0]     buf_rd_r;
  logic [31:0]    buf_data_r;
  logic [31:0]    busy_r;
  logic [CW-1:0]  out_cnt_r;
  logic [SW-1:0]  starve_cnt_r;

  logic           wb_go_s;
  logic           drain_s;
  logic           issue_s;
  logic           starve_s;
  logic           raw1_s;
  logic           raw2_s;
  logic [31:0]    busy_clr_s;
  logic [31:0]    busy_set_s;
  logic [31:0]    busy_nx_s;

  // Arbitration and handshake decode from registered state
  always_comb begin
    wb_go_s   = wb_we && (wb_rd != 5'd0);
    drain_s   = (buf_state_r == BUF_FULL) && !wb_go_s;
    mc_ready  = (buf_state_r == BUF_EMPTY);
    iss_ready = !busy_r[iss_rd] && (out_cnt_r < MAX_CNT);
    issue_s   = iss_valid && iss_ready;
    starve_s  = (starve_cnt_r >= STARVE_CAP);
  end

  // RAW hazard detection; with bypass, a register being written in rf_* is forwarded instead
  always_comb begin
    raw1_s = (id_rs1 != 5'd0) && busy_r[id_rs1];
    raw2_s = (id_rs2 != 5'd0) && busy_r[id_rs2];
`ifdef RFW_BYPASS_EN
    raw1_s = raw1_s && !(rf_we && (rf_rd == id_rs1));
    raw2_s = raw2_s && !(rf_we && (rf_rd == id_rs2));
    byp1_hit  = rf_we && (rf_rd != 5'd0) && (rf_rd == id_rs1);
    byp2_hit  = rf_we && (rf_rd != 5'd0) && (rf_rd == id_rs2);
    byp1_data = rf_wdata;
    byp2_data = rf_wdata;
`endif
    id_stall = raw1_s | raw2_s | starve_s;
  end

  // Next busy vector: drain clears its bit, accepted issue sets its bit, x0 is never busy
  always_comb begin
    busy_clr_s = drain_s ? (32'd1 << buf_rd_r) : 32'd0;
    busy_set_s = issue_s ? (32'd1 << iss_rd) : 32'd0;
    busy_nx_s  = ((busy_r & ~busy_clr_s) | busy_set_s) & ~32'd1;
  end

  // Skid buffer FSM with starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_state_r  <= BUF_EMPTY;
      buf_rd_r     <= 5'd0;
      buf_data_r   <= 32'd0;
      starve_cnt_r <= '0;
    end else begin
      case (buf_state_r)
        BUF_EMPTY: begin
          starve_cnt_r <= '0;
          if (mc_valid) begin
            buf_state_r <= BUF_FULL;
            buf_rd_r    <= mc_rd;
            buf_data_r  <= mc_data;
          end
        end
        BUF_FULL: begin
          if (drain_s) begin
            buf_state_r  <= BUF_EMPTY;
            starve_cnt_r <= '0;
          end else if (starve_cnt_r < STARVE_CAP) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
          end
        end
        default: begin
          buf_state_r  <= BUF_EMPTY;
          starve_cnt_r <= '0;
        end
      endcase
    end
  end

  // Busy scoreboard and outstanding-op counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 32'd0;
      out_cnt_r <= '0;
    end else begin
      busy_r <= busy_nx_s;
      case ({issue_s, drain_s})
        2'b10: if (out_cnt_r < MAX_CNT) out_cnt_r <= out_cnt_r + CW'(1);
        2'b01: if (out_cnt_r != '0) out_cnt_r <= out_cnt_r - CW'(1);
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // Register-file write port: WB first, then buffer; an x0 drain leaves rf_we low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (wb_go_s) begin
      rf_we    <= 1'b1;
      rf_rd    <= wb_rd;
      rf_wdata <= wb_data;
    end else if (drain_s && (buf_rd_r != 5'd0)) begin
      rf_we    <= 1'b1;
      rf_rd    <= buf_rd_r;
      rf_wdata <= buf_data_r;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed self-checking bench for rf_write_scheduler (default parameters MAX_OUT=4, STARVE_LIM=8).
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef RFW_BYPASS_EN
  logic        byp1_hit;
  logic [31:0] byp1_data;
  logic        byp2_hit;
  logic [31:0] byp2_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_scheduler dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_stall(id_stall),
`ifdef RFW_BYPASS_EN
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
`endif
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    iss_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h11;
    mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h55;
    step();
    mc_valid = 1'b0; id_rs1 = 5'd5; iss_rd = 5'd5;
    #1;
    n_checks++;
    if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_full: mc_ready=%b want 0", mc_ready); end
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: id_stall=%b want 1", id_stall); end
    rst = 1'b1; wb_we = 1'b0;
    #1;
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata} !== 38'd0) begin
      n_fail++; $display("FAIL reset_rf: we=%b rd=%0d data=%h want all 0", rf_we, rf_rd, rf_wdata);
    end
    n_checks++;
    if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready: got %b want 1", mc_ready); end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_id_stall: got %b want 0", id_stall); end
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready: got %b want 1", iss_ready); end
    step();
    rst = 1'b0; id_rs1 = 5'd0;
  endtask

  task automatic test_wb_write();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    step();
    wb_we = 1'b0;
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_write: we=%b rd=%0d data=%h want 1/3/deadbeef", rf_we, rf_rd, rf_wdata);
    end
    step();
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_idle_hold: we=%b rd=%0d data=%h want 0/3/deadbeef", rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_mc_path();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL issue7_ready: got %b want 1", iss_ready); end
    step();
    iss_valid = 1'b0; id_rs1 = 5'd7;
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall7: got %b want 1", id_stall); end
    n_checks++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reissue7_refused: got %b want 0", iss_ready); end
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h1234;
    #1;
    n_checks++;
    if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL mc_ready_empty: got %b want 1", mc_ready); end
    step();
    mc_valid = 1'b0;
    #1;
    n_checks++;
    if ({mc_ready, id_stall, rf_we} !== 3'b010) begin
      n_fail++; $display("FAIL buf_full_state: mc_ready/stall/rf_we=%b%b%b want 010", mc_ready, id_stall, rf_we);
    end
    step();
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'h1234}) begin
      n_fail++; $display("FAIL mc_drain: we=%b rd=%0d data=%h want 1/7/1234", rf_we, rf_rd, rf_wdata);
    end
    n_checks++;
    if ({id_stall, mc_ready} !== 2'b01) begin
      n_fail++; $display("FAIL post_drain: stall=%b mc_ready=%b want 0/1", id_stall, mc_ready);
    end
    id_rs1 = 5'd0;
  endtask

  task automatic test_starvation();
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hA0;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
    step();
    mc_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wb_data = 32'hA0 + 32'(i);
      step();
      if (i == 7) begin
        n_checks++;
        if (id_stall !== 1'b0) begin n_fail++; $display("FAIL starve_early: stall=%b after 7 cycles want 0", id_stall); end
      end
    end
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: stall=%b after 8 cycles want 1", id_stall); end
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd1, 32'hA8}) begin
      n_fail++; $display("FAIL starve_wb_wins: we=%b rd=%0d data=%h want 1/1/a8", rf_we, rf_rd, rf_wdata);
    end
    wb_we = 1'b0;
    step();
    n_checks++;
    if ({rf_we, rf_rd, rf_wdata, id_stall} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
      n_fail++; $display("FAIL starve_drain: we=%b rd=%0d data=%h stall=%b want 1/9/99/0", rf_we, rf_rd, rf_wdata, id_stall);
    end
  endtask

  task automatic test_outstanding_limit();
    for (int r = 11; r <= 14; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      step();
    end
    iss_valid = 1'b0; iss_rd = 5'd15;
    #1;
    n_checks++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_out_block: iss_ready=%b want 0", iss_ready); end
    mc_valid = 1'b1; mc_rd = 5'd11; mc_data = 32'hB;
    step();
    mc_valid = 1'b0;
    n_checks++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL max_out_before_drain: iss_ready=%b want 0", iss_ready); end
    step();
    n_checks++;
    if ({iss_ready, rf_we, rf_rd} !== {1'b1, 1'b1, 5'd11}) begin
      n_fail++; $display("FAIL max_out_after_drain: iss_ready=%b rf_we=%b rd=%0d want 1/1/11", iss_ready, rf_we, rf_rd);
    end
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL issue_x0_ready: got %b want 1", iss_ready); end
    step();
    iss_valid = 1'b0; iss_rd = 5'd15; id_rs1 = 5'd12;
    #1;
    n_checks++;
    if ({iss_ready, id_stall} !== 2'b01) begin
      n_fail++; $display("FAIL issue_x0_counted: iss_ready=%b stall=%b want 0/1", iss_ready, id_stall);
    end
    id_rs1 = 5'd0;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    step();
    wb_we = 1'b0;
    n_checks++;
    if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_x0: rf_we=%b want 0", rf_we); end
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h55;
    step();
    mc_valid = 1'b0;
    step();
    n_checks++;
    if ({rf_we, rf_rd, iss_ready, mc_ready} !== {1'b0, 5'd11, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL mc_x0_drain: rf_we=%b rd=%0d iss_ready=%b mc_ready=%b want 0/11/1/1", rf_we, rf_rd, iss_ready, mc_ready);
    end
  endtask

`ifdef RFW_BYPASS_EN
  task automatic test_bypass();
    wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'hCAFE;
    step();
    wb_we = 1'b0; id_rs2 = 5'd10;
    #1;
    n_checks++;
    if ({byp2_hit, byp2_data} !== {1'b1, 32'hCAFE}) begin
      n_fail++; $display("FAIL bypass2: hit=%b data=%h want 1/cafe", byp2_hit, byp2_data);
    end
    n_checks++;
    if (byp1_hit !== 1'b0) begin n_fail++; $display("FAIL bypass1_nohit: hit=%b want 0", byp1_hit); end
    id_rs2 = 5'd0;
  endtask
`endif

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    mc_valid = 1'b0; mc_rd = 5'd0; mc_data = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    test_reset();
    test_wb_write();
    test_mc_path();
    test_starvation();
    test_outstanding_limit();
`ifdef RFW_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
